goertzel_tone_meter: RTL and testbench

- Digital single-bin tone detector: the receive end of the AC stimulus/response measurement path.
- A block of signed ADC samples of a filter output (e.g. the bandpass Vout node) is run through a Goertzel recurrence at a programmed bin frequency.
- Returns the bin power |X(k)|^2 for gain (dB) evaluation, one result per block.
- Sits between the ADC sample stream and the host/result register interface.

---
 rtl/goertzel_tone_meter_if.sv | 30 +++
 rtl/goertzel_tone_meter.sv | 152 +++++++++++++++
 tb/tb_goertzel_tone_meter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/goertzel_tone_meter_if.sv
// Control, sample-stream and result signals of the Goertzel tone meter.
// The master drives block control, samples and result acceptance.
interface goertzel_tone_meter_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned COEF_W  = 20,
  parameter int unsigned STATE_W = 32,
  parameter int unsigned LEN_W   = 16
);
  logic                        start;
  logic [LEN_W-1:0]            block_len;
  logic signed [COEF_W-1:0]    coef;
  logic                        s_valid;
  logic signed [DATA_W-1:0]    s_data;
  logic                        s_ready;
  logic                        res_valid;
  logic                        res_ready;
  logic signed [2*STATE_W-1:0] res_power;
  logic                        overflow;
  logic                        busy;

  modport master (
    output start, block_len, coef, s_valid, s_data, res_ready,
    input  s_ready, res_valid, res_power, overflow, busy
  );

  modport slave (
    input  start, block_len, coef, s_valid, s_data, res_ready,
    output s_ready, res_valid, res_power, overflow, busy
  );
endinterface

// File: rtl/goertzel_tone_meter.sv
// Single-bin Goertzel detector: runs a sample block through the recurrence,
// then evaluates |X(k)|^2 with one shared multiply per power-phase cycle.
module goertzel_tone_meter #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned COEF_W  = 20,
  parameter int unsigned FRAC    = 16,
  parameter int unsigned STATE_W = 32,
  parameter int unsigned LEN_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  goertzel_tone_meter_if.slave bus
);
  localparam int unsigned PROD_W = COEF_W + STATE_W;
  // Wide enough for data + shifted product - s2 without loss.
  localparam int unsigned SUM_W  = PROD_W - FRAC + 2;
  localparam int unsigned ACC_W  = 2 * STATE_W;

  typedef enum logic [2:0] {IDLE, ACCUM, P_A, P_B, P_C, P_D, DONE} state_e;

  state_e                     state_q, state_d;
  logic [LEN_W-1:0]           len_q, len_d, cnt_q, cnt_d;
  logic signed [COEF_W-1:0]   coef_q, coef_d;
  logic signed [STATE_W-1:0]  s1_q, s1_d, s2_q, s2_d, q_q, q_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d, pow_q, pow_d;
  logic                       ovf_q, ovf_d;
  logic                       s_ready_q, s_ready_d;
  logic                       res_valid_q, res_valid_d;
  logic                       busy_q, busy_d;

  logic signed [PROD_W-1:0]   cmul_c, cshr_c;
  logic signed [SUM_W-1:0]    s0_c;
  logic signed [STATE_W-1:0]  pa_c, pb_c;
  logic signed [ACC_W-1:0]    pmul_c;

  // Recurrence datapath and the shared power-phase multiplier.
  always_comb begin
    cmul_c = PROD_W'(coef_q) * PROD_W'(s1_q);
    cshr_c = cmul_c >>> FRAC;
    s0_c   = SUM_W'(bus.s_data) + SUM_W'(cshr_c) - SUM_W'(s2_q);
    pa_c   = s1_q;
    pb_c   = s1_q;
    case (state_q)
      P_B:     begin pa_c = s2_q; pb_c = s2_q; end
      P_D:     begin pa_c = q_q;  pb_c = s2_q; end
      default: begin pa_c = s1_q; pb_c = s1_q; end
    endcase
    pmul_c = ACC_W'(pa_c) * ACC_W'(pb_c);
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    coef_d      = coef_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    q_d         = q_q;
    acc_d       = acc_q;
    pow_d       = pow_q;
    ovf_d       = ovf_q;
    s_ready_d   = 1'b0;
    res_valid_d = 1'b0;
    busy_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d   = bus.block_len;
          coef_d  = bus.coef;
          s1_d    = '0;
          s2_d    = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = (bus.block_len == '0) ? P_A : ACCUM;
        end
      end
      ACCUM: begin
        if (bus.s_valid && s_ready_q) begin
          s2_d  = s1_q;
          s1_d  = s0_c[STATE_W-1:0];
          // Sticky flag when s0 does not survive truncation to STATE_W.
          if (s0_c != SUM_W'($signed(s0_c[STATE_W-1:0]))) ovf_d = 1'b1;
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) state_d = P_A;
        end
      end
      P_A: begin
        acc_d   = pmul_c;
        state_d = P_B;
      end
      P_B: begin
        acc_d   = acc_q + pmul_c;
        state_d = P_C;
      end
      P_C: begin
        q_d     = STATE_W'(cshr_c);
        state_d = P_D;
      end
      P_D: begin
        pow_d   = acc_q - pmul_c;
        state_d = DONE;
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    s_ready_d   = (state_d == ACCUM);
    res_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      coef_q      <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      q_q         <= '0;
      acc_q       <= '0;
      pow_q       <= '0;
      ovf_q       <= 1'b0;
      s_ready_q   <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      coef_q      <= coef_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      q_q         <= q_d;
      acc_q       <= acc_d;
      pow_q       <= pow_d;
      ovf_q       <= ovf_d;
      s_ready_q   <= s_ready_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_power = pow_q;
  assign bus.overflow  = ovf_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_goertzel_tone_meter.sv
// Bench for goertzel_tone_meter: directed blocks against a plain-arithmetic
// Goertzel model, with literal expectations for the reference tones.
module tb_goertzel_tone_meter;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned COEF_W  = 20;
  localparam int unsigned FRAC    = 16;
  localparam int unsigned STATE_W = 32;
  localparam int unsigned LEN_W   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  goertzel_tone_meter_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .STATE_W(STATE_W), .LEN_W(LEN_W)) bus ();

  goertzel_tone_meter #(.DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC(FRAC), .STATE_W(STATE_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int     total = 0;
  int     bad   = 0;
  bit     res_allowed = 1'b0;
  longint exp_pw = 0;
  bit     exp_ov = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference Goertzel: exact arithmetic, states wrapped to 32 bits.
  function automatic void model(input int xs[$], input int cf, output longint pw, output bit ov);
    longint s1 = 0, s2 = 0, s0, c, q;
    c  = longint'(cf);
    ov = 1'b0;
    foreach (xs[i]) begin
      s0 = longint'(xs[i]) + ((c * s1) >>> FRAC) - s2;
      s2 = s1;
      s1 = longint'(int'(s0));
      if (s1 != s0) ov = 1'b1;
    end
    q  = longint'(int'((c * s1) >>> FRAC));
    pw = s1 * s1 + s2 * s2 - q * s2;
  endfunction

  // Every cycle: a result may only be presented when one is due, and must match the model.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (!res_allowed) check("no_spurious_result", longint'(bus.res_valid), 0);
      else if (bus.res_valid) begin
        check("res_power", longint'(bus.res_power), exp_pw);
        check("overflow", longint'(bus.overflow), longint'(exp_ov));
      end
    end
  end

  task automatic feed(input string tag, input int x);
    int budget = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = DATA_W'(x);
    while (!bus.s_ready && budget < 20) begin
      step();
      budget++;
    end
    if (budget >= 20) check({tag, "_accept_wait"}, longint'(bus.s_ready), 1);
    step();
    bus.s_valid = 1'b0;
  endtask

  task automatic run_block(input string tag, input int xs[$], input int cf, input bit gaps,
                           input bit chk_pw, input longint lit_pw, input bit lit_ov, input int hold);
    longint pw;
    bit     ov;
    int     lat = 0;
    bit     sr_seen = 1'b0;
    model(xs, cf, pw, ov);
    exp_pw = pw;
    exp_ov = ov;
    if (chk_pw) check({tag, "_model_power"}, pw, lit_pw);
    check({tag, "_model_ovf"}, longint'(ov), longint'(lit_ov));

    bus.start     = 1'b1;
    bus.block_len = LEN_W'(xs.size());
    bus.coef      = COEF_W'(cf);
    step();
    bus.start = 1'b0;
    check({tag, "_busy"}, longint'(bus.busy), 1);
    if (bus.s_ready) sr_seen = 1'b1;

    foreach (xs[i]) begin
      if (gaps) begin
        bus.s_valid = 1'b0;
        if (i == xs.size() / 2) begin
          bus.start     = 1'b1;
          bus.block_len = LEN_W'(7);
          bus.coef      = COEF_W'(0);
        end
        step();
        bus.start = 1'b0;
      end
      feed(tag, xs[i]);
    end

    res_allowed = 1'b1;
    while (!bus.res_valid && lat < 20) begin
      if (bus.s_ready) sr_seen = 1'b1;
      step();
      lat++;
    end
    check({tag, "_latency"}, longint'(lat), 4);
    if (xs.size() == 0) check({tag, "_s_ready_never"}, longint'(sr_seen), 0);
    if (chk_pw) check({tag, "_power_lit"}, longint'(bus.res_power), lit_pw);
    check({tag, "_ovf_lit"}, longint'(bus.overflow), longint'(lit_ov));

    repeat (hold) step();
    if (hold > 0) check({tag, "_held_valid"}, longint'(bus.res_valid), 1);

    // Consume the result; a simultaneous start must be ignored.
    bus.res_ready = 1'b1;
    bus.start     = 1'b1;
    step();
    bus.res_ready = 1'b0;
    bus.start     = 1'b0;
    res_allowed   = 1'b0;
    check({tag, "_valid_dropped"}, longint'(bus.res_valid), 0);
    check({tag, "_idle_after"}, longint'(bus.busy), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_ready"}, longint'(bus.s_ready), 0);
    check({tag, "_res_valid"}, longint'(bus.res_valid), 0);
    check({tag, "_busy"}, longint'(bus.busy), 0);
    check({tag, "_overflow"}, longint'(bus.overflow), 0);
    check({tag, "_res_power"}, longint'(bus.res_power), 0);
  endtask

  int fs4[$];
  int dc[$];
  int big[$];
  int none[$];

  initial begin
    bus.start     = 1'b0;
    bus.block_len = '0;
    bus.coef      = '0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.res_ready = 1'b0;

    fs4.push_back(1000); fs4.push_back(0); fs4.push_back(-1000); fs4.push_back(0);
    repeat (4) dc.push_back(100);
    repeat (1000) big.push_back(32767);

    rst = 1'b1;
    step();
    step();
    check_reset_vals("reset");
    rst = 1'b0;
    step();

    run_block("fs4", fs4, 0, 1'b0, 1'b1, 64'sd4000000, 1'b0, 0);
    run_block("dc", dc, 32'h20000, 1'b0, 1'b1, 64'sd160000, 1'b0, 10);
    run_block("dc_stall", dc, 32'h20000, 1'b1, 1'b1, 64'sd160000, 1'b0, 2);
    run_block("zero_len", none, 32'h20000, 1'b0, 1'b1, 64'sd0, 1'b0, 0);
    run_block("ovf", big, 32'h20000, 1'b0, 1'b0, 64'sd0, 1'b1, 3);
    run_block("fs4_after_ovf", fs4, 0, 1'b0, 1'b1, 64'sd4000000, 1'b0, 0);

    // Abort a block halfway through with reset.
    bus.start     = 1'b1;
    bus.block_len = LEN_W'(4);
    bus.coef      = '0;
    step();
    bus.start = 1'b0;
    feed("rst_mid", 1000);
    feed("rst_mid", 0);
    rst = 1'b1;
    step();
    check_reset_vals("rst_mid");
    rst = 1'b0;
    repeat (6) step();
    check("rst_mid_no_result", longint'(bus.res_valid), 0);
    run_block("fs4_after_rst", fs4, 0, 1'b0, 1'b1, 64'sd4000000, 1'b0, 0);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
